// File: rtl/board_input_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// board_pkg
// Shared types and constants for the board input controller slice.
//   state_t          : controller FSM encoding (WAIT_CFG / CFG_OK / RUN)
//   DATA_W_DEFAULT   : default switch bus / config value width
//   DEBOUNCE_DEFAULT : debounce length for the real board clock
//   CNT_W_DEFAULT    : debounce counter width matching DEBOUNCE_DEFAULT
//   SIM_DEBOUNCE     : short debounce length used in simulation
// ---------------------------------------------------------------------------
package board_pkg;

  typedef enum logic [1:0] {
    WAIT_CFG = 2'd0,
    CFG_OK   = 2'd1,
    RUN      = 2'd2
  } state_t;

  localparam int DATA_W_DEFAULT   = 16;
  localparam int DEBOUNCE_DEFAULT = 500000;
  localparam int CNT_W_DEFAULT    = 20;
  localparam int SIM_DEBOUNCE     = 4;

endpackage

// File: rtl/board_input_ctrl_if.sv
// ---------------------------------------------------------------------------
// board_input_if
// Bundles the board-pin side inputs and the conditioned configuration
// outputs of board_input_ctrl.
//   in_sw, in_btn_*            : raw switches / buttons (driven by master)
//   init_floors/resistance     : captured configuration values
//   cpu_rst_n                  : active-low CPU reset
//   o_cfg_ok, o_err            : status flags
//   o_last, o_last_src         : only with BOARD_INPUT_LAST_VALUE_EN defined
// Modports: master = board side, slave = board_input_ctrl.
// ---------------------------------------------------------------------------
interface board_input_if
  import board_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
);

  logic [DATA_W-1:0] in_sw;
  logic              in_btn_floors;
  logic              in_btn_resistance;
  logic              in_btn_run;
  logic [DATA_W-1:0] init_floors;
  logic [DATA_W-1:0] init_resistance;
  logic              cpu_rst_n;
  logic              o_cfg_ok;
  logic              o_err;
`ifdef BOARD_INPUT_LAST_VALUE_EN
  logic [DATA_W-1:0] o_last;
  logic [1:0]        o_last_src;
`endif

  modport master (
    output in_sw, in_btn_floors, in_btn_resistance, in_btn_run,
`ifdef BOARD_INPUT_LAST_VALUE_EN
    input  o_last, o_last_src,
`endif
    input  init_floors, init_resistance, cpu_rst_n, o_cfg_ok, o_err
  );

  modport slave (
    input  in_sw, in_btn_floors, in_btn_resistance, in_btn_run,
`ifdef BOARD_INPUT_LAST_VALUE_EN
    output o_last, o_last_src,
`endif
    output init_floors, init_resistance, cpu_rst_n, o_cfg_ok, o_err
  );

endinterface

// File: rtl/board_input_ctrl_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser, stability counter, debounced level and a one-cycle
// press pulse on a debounced 0->1 transition (release gives no pulse).
//   in_clk, in_rst : clock, asynchronous active-low reset
//   in_btn         : raw asynchronous button, high = pressed
//   press          : registered one-cycle pulse on debounced press
// ---------------------------------------------------------------------------
module btn_debounce
  import board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_btn,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // The counter only runs while the synced input disagrees with the
  // debounced level; any agreement (i.e. a bounce back) restarts it.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= in_btn;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_q2;
        cnt   <= '0;
        press <= sync_q2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_input_ctrl.sv
// ---------------------------------------------------------------------------
// board_input_ctrl
// Conditions raw board switches and buttons into configuration values and
// the CPU reset. Switches are synchronised, the three buttons debounced,
// and a small FSM captures values and sequences configure / run phases.
//   in_clk : board clock
//   in_rst : asynchronous active-low reset
//   bus    : board_input_if.slave (raw inputs in, config/status out)
// Optional feature macro: BOARD_INPUT_LAST_VALUE_EN adds o_last/o_last_src.
// ---------------------------------------------------------------------------
module board_input_ctrl
  import board_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic          in_clk,
  input  logic          in_rst,
  board_input_if.slave  bus
);

  state_t            state;
  logic [DATA_W-1:0] sw_q1;
  logic [DATA_W-1:0] sw_q2;
  logic              floors_press;
  logic              res_press;
  logic              run_press;

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      sw_q1 <= '0;
      sw_q2 <= '0;
    end else begin
      sw_q1 <= bus.in_sw;
      sw_q2 <= sw_q1;
    end
  end

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_floors (
    .in_clk(in_clk), .in_rst(in_rst), .in_btn(bus.in_btn_floors), .press(floors_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_res (
    .in_clk(in_clk), .in_rst(in_rst), .in_btn(bus.in_btn_resistance), .press(res_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_run (
    .in_clk(in_clk), .in_rst(in_rst), .in_btn(bus.in_btn_run), .press(run_press)
  );

  // cpu_rst_n and o_cfg_ok follow the current state, so they lag a state
  // change by one clock. The if/else-if chain gives floors > resistance > run.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state               <= WAIT_CFG;
      bus.init_floors     <= '0;
      bus.init_resistance <= '0;
      bus.cpu_rst_n       <= 1'b0;
      bus.o_cfg_ok        <= 1'b0;
      bus.o_err           <= 1'b0;
`ifdef BOARD_INPUT_LAST_VALUE_EN
      bus.o_last          <= '0;
      bus.o_last_src      <= 2'b00;
`endif
    end else begin
      bus.cpu_rst_n <= (state == RUN);
      bus.o_cfg_ok  <= (state != WAIT_CFG);
      case (state)
        WAIT_CFG, CFG_OK: begin
          if (floors_press) begin
            if (sw_q2 == '0) begin
              bus.o_err <= 1'b1;
            end else begin
              bus.init_floors <= sw_q2;
              bus.o_err       <= 1'b0;
`ifdef BOARD_INPUT_LAST_VALUE_EN
              bus.o_last      <= sw_q2;
              bus.o_last_src  <= 2'b01;
`endif
              if (bus.init_resistance != '0) state <= CFG_OK;
            end
          end else if (res_press) begin
            if (sw_q2 == '0) begin
              bus.o_err <= 1'b1;
            end else begin
              bus.init_resistance <= sw_q2;
              bus.o_err           <= 1'b0;
`ifdef BOARD_INPUT_LAST_VALUE_EN
              bus.o_last          <= sw_q2;
              bus.o_last_src      <= 2'b10;
`endif
              if (bus.init_floors != '0) state <= CFG_OK;
            end
          end else if (run_press) begin
            if (state == WAIT_CFG) bus.o_err <= 1'b1;
            else                   state     <= RUN;
          end
        end
        RUN: begin
          if (floors_press || res_press) bus.o_err <= 1'b1;
          else if (run_press)            state     <= CFG_OK;
        end
        default: state <= WAIT_CFG;
      endcase
    end
  end

endmodule

// File: tb/tb_board_input_ctrl.sv
// ---------------------------------------------------------------------------
// tb_board_input_ctrl
// Directed bench for board_input_ctrl with DEBOUNCE_CYCLES=4. Each step
// pushes the outputs it expects onto a scoreboard queue; checkOutput pops
// and compares once the button activity has settled.
// ---------------------------------------------------------------------------
module tb_board_input_ctrl;

  typedef struct packed {
    logic [15:0] floors;
    logic [15:0] res;
    logic        cpu;
    logic        cfg;
    logic        err;
  } exp_t;

  logic  in_clk = 1'b0;
  logic  in_rst = 1'b0;
  exp_t  sb[$];
  int    checks = 0;
  int    failures = 0;
  int    floors_pulses = 0;

  board_input_if #(.DATA_W(16)) bus ();

  board_input_ctrl #(.DATA_W(16), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .in_clk(in_clk),
    .in_rst(in_rst),
    .bus   (bus)
  );

  always #5 in_clk = ~in_clk;

  // Counts debounced floors press pulses to confirm a bouncy press gives one.
  always @(negedge in_clk) begin
    if (dut.u_db_floors.press === 1'b1) floors_pulses++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge in_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] sw, input logic f, input logic r,
                               input logic run);
    bus.in_sw             = sw;
    bus.in_btn_floors     = f;
    bus.in_btn_resistance = r;
    bus.in_btn_run        = run;
  endtask

  task automatic pushExpected(input logic [15:0] f, input logic [15:0] r,
                              input logic cpu, input logic cfg, input logic err);
    exp_t e;
    e.floors = f;
    e.res    = r;
    e.cpu    = cpu;
    e.cfg    = cfg;
    e.err    = err;
    sb.push_back(e);
  endtask

  task automatic checkValue(input string tag, input logic [15:0] observed,
                            input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string step);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s scoreboard empty observed=0 expected=1", step);
      return;
    end
    e = sb.pop_front();
    checkValue({step, ".init_floors"},     bus.init_floors,          e.floors);
    checkValue({step, ".init_resistance"}, bus.init_resistance,      e.res);
    checkValue({step, ".cpu_rst_n"},       {15'd0, bus.cpu_rst_n},   {15'd0, e.cpu});
    checkValue({step, ".o_cfg_ok"},        {15'd0, bus.o_cfg_ok},    {15'd0, e.cfg});
    checkValue({step, ".o_err"},           {15'd0, bus.o_err},       {15'd0, e.err});
  endtask

  // Clean press: switches settle, button held 10 cycles, then release settles.
  task automatic pressButtons(input logic [15:0] sw, input logic f, input logic r,
                              input logic run);
    applyStimulus(sw, 1'b0, 1'b0, 1'b0);
    tick(3);
    applyStimulus(sw, f, r, run);
    tick(10);
    applyStimulus(sw, 1'b0, 1'b0, 1'b0);
    tick(8);
  endtask

  initial begin
    // Reset state
    applyStimulus(16'd0, 1'b0, 1'b0, 1'b0);
    in_rst = 1'b0;
    tick(3);
    pushExpected(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset");
    in_rst = 1'b1;
    tick(2);

    // Floors capture with latency boundary: unchanged after edge 6, set after 7
    applyStimulus(16'd100, 1'b0, 1'b0, 1'b0);
    tick(3);
    pushExpected(16'd100, 16'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'd100, 1'b1, 1'b0, 1'b0);
    tick(6);
    checkValue("floors_latency_edge6", bus.init_floors, 16'd0);
    tick(1);
    checkValue("floors_latency_edge7", bus.init_floors, 16'd100);
    tick(3);
    applyStimulus(16'd100, 1'b0, 1'b0, 1'b0);
    tick(8);
    checkOutput("floors100");

    pushExpected(16'd100, 16'd5, 1'b0, 1'b1, 1'b0);
    pressButtons(16'd5, 1'b0, 1'b1, 1'b0);
    checkOutput("res5");

    // Run: RUN entered at edge 7, cpu_rst_n follows one edge later
    pushExpected(16'd100, 16'd5, 1'b1, 1'b1, 1'b0);
    applyStimulus(16'd5, 1'b0, 1'b0, 1'b1);
    tick(7);
    checkValue("cpu_rst_n_edge7", {15'd0, bus.cpu_rst_n}, 16'd0);
    tick(1);
    checkValue("cpu_rst_n_edge8", {15'd0, bus.cpu_rst_n}, 16'd1);
    tick(2);
    applyStimulus(16'd5, 1'b0, 1'b0, 1'b0);
    tick(8);
    checkOutput("run_on");

    pushExpected(16'd100, 16'd5, 1'b0, 1'b1, 1'b0);
    pressButtons(16'd5, 1'b0, 1'b0, 1'b1);
    checkOutput("run_off");

    // Bouncy floors press: 1,1,0,0,1,1,0,0 then held -> a single pulse
    pushExpected(16'd42, 16'd5, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'd42, 1'b0, 1'b0, 1'b0);
    tick(3);
    floors_pulses = 0;
    for (int i = 0; i < 8; i++) begin
      bus.in_btn_floors = ((i % 4) < 2);
      tick(1);
    end
    bus.in_btn_floors = 1'b1;
    tick(6);
    checkValue("bounce_edge6", bus.init_floors, 16'd100);
    tick(1);
    checkValue("bounce_edge7", bus.init_floors, 16'd42);
    tick(3);
    bus.in_btn_floors = 1'b0;
    tick(8);
    checkValue("bounce_pulses", 16'(floors_pulses), 16'd1);
    checkOutput("bounce42");

    // Reset back to WAIT_CFG between clock edges
    pushExpected(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    in_rst = 1'b0;
    #2;
    checkOutput("reset_cfg");
    tick(2);
    in_rst = 1'b1;
    tick(2);

    pushExpected(16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    pressButtons(16'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("floors_zero");

    pushExpected(16'd7, 16'd0, 1'b0, 1'b0, 1'b0);
    pressButtons(16'd7, 1'b1, 1'b0, 1'b0);
    checkOutput("floors7");

    pushExpected(16'd7, 16'd0, 1'b0, 1'b0, 1'b1);
    pressButtons(16'd7, 1'b0, 1'b0, 1'b1);
    checkOutput("run_in_wait");

    pushExpected(16'd7, 16'd5, 1'b0, 1'b1, 1'b0);
    pressButtons(16'd5, 1'b0, 1'b1, 1'b0);
    checkOutput("res5_again");

    pushExpected(16'd7, 16'd5, 1'b1, 1'b1, 1'b0);
    pressButtons(16'd5, 1'b0, 1'b0, 1'b1);
    checkOutput("run_on2");

    pushExpected(16'd7, 16'd5, 1'b1, 1'b1, 1'b1);
    pressButtons(16'd9, 1'b1, 1'b0, 1'b0);
    checkOutput("floors_in_run");

    pushExpected(16'd7, 16'd5, 1'b0, 1'b1, 1'b1);
    pressButtons(16'd9, 1'b0, 1'b0, 1'b1);
    checkOutput("run_off2");

    // Floors and resistance together: floors wins, resistance dropped
    pushExpected(16'd3, 16'd5, 1'b0, 1'b1, 1'b0);
    pressButtons(16'd3, 1'b1, 1'b1, 1'b0);
    checkOutput("simultaneous");

    pushExpected(16'd3, 16'd5, 1'b1, 1'b1, 1'b0);
    pressButtons(16'd3, 1'b0, 1'b0, 1'b1);
    checkOutput("run_on3");

    // Asynchronous reset mid-RUN, checked before any clock edge
    pushExpected(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    in_rst = 1'b0;
    #2;
    checkOutput("reset_mid_run");
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
